// File: rtl/flash_boot_loader.sv
// Boot-time copier: moves the BIOS region (and optionally the MegaROM region) from flash to RAM byte by byte.
// Define BOOT_MEGAROM_EN to copy the MegaROM region after the BIOS region.
module flash_boot_loader #(
    parameter logic [23:0] BIOS_SRC  = 24'h10_0000,
    parameter logic [23:0] BIOS_DST  = 24'h70_0000,
    parameter logic [23:0] BIOS_SIZE = 24'h02_4000,
    parameter logic [23:0] MEGA_SRC  = 24'h20_0000,
    parameter logic [23:0] MEGA_DST  = 24'h40_0000,
    parameter logic [23:0] MEGA_SIZE = 24'h20_0000,
    parameter logic [7:0]  TIMEOUT   = 8'd255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic        FLASH_REQ,
    output logic [23:0] FLASH_ADDR,
    input  logic        FLASH_ACK,
    input  logic [7:0]  FLASH_RDATA,
    output logic        RAM_REQ,
    output logic [23:0] RAM_ADDR,
    output logic [7:0]  RAM_WDATA,
    input  logic        RAM_ACK
);

`ifdef BOOT_MEGAROM_EN
    localparam bit MEGA_ON = 1'b1;
`else
    localparam bit MEGA_ON = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, FREAD, RWRITE, FIN, FAIL} state_t;

    state_t      state, state_nx;
    logic        region, region_nx;
    logic [23:0] offset, offset_nx;
    logic [7:0]  wait_cnt, wait_nx;
    logic [7:0]  wdata, wdata_nx;
    logic [23:0] cur_src;
    logic [23:0] cur_dst;
    logic [23:0] cur_last;
    logic        timed_out;
    logic        mega_next;

    // Region 1 (MegaROM) is only ever selected when the feature is built in.
    assign cur_src   = region ? MEGA_SRC : BIOS_SRC;
    assign cur_dst   = region ? MEGA_DST : BIOS_DST;
    assign cur_last  = (region ? MEGA_SIZE : BIOS_SIZE) - 24'd1;
    assign timed_out = (wait_cnt == TIMEOUT - 8'd1);
    assign mega_next = MEGA_ON && (MEGA_SIZE != 24'd0);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            region   <= 1'b0;
            offset   <= 24'd0;
            wait_cnt <= 8'd0;
            wdata    <= 8'd0;
        end else begin
            state    <= state_nx;
            region   <= region_nx;
            offset   <= offset_nx;
            wait_cnt <= wait_nx;
            wdata    <= wdata_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        region_nx = region;
        offset_nx = offset;
        wait_nx   = 8'd0;
        wdata_nx  = wdata;
        unique case (state)
            IDLE, FIN, FAIL: begin
                if (START) begin
                    offset_nx = 24'd0;
                    // Empty regions are skipped before any access is issued.
                    if (BIOS_SIZE != 24'd0) begin
                        region_nx = 1'b0;
                        state_nx  = FREAD;
                    end else if (mega_next) begin
                        region_nx = 1'b1;
                        state_nx  = FREAD;
                    end else begin
                        state_nx = FIN;
                    end
                end
            end
            FREAD: begin
                if (FLASH_ACK) begin
                    wdata_nx = FLASH_RDATA;
                    state_nx = RWRITE;
                end else if (timed_out) begin
                    state_nx = FAIL;
                end else begin
                    wait_nx = wait_cnt + 8'd1;
                end
            end
            RWRITE: begin
                if (RAM_ACK) begin
                    if (offset != cur_last) begin
                        offset_nx = offset + 24'd1;
                        state_nx  = FREAD;
                    end else if (!region && mega_next) begin
                        region_nx = 1'b1;
                        offset_nx = 24'd0;
                        state_nx  = FREAD;
                    end else begin
                        state_nx = FIN;
                    end
                end else if (timed_out) begin
                    state_nx = FAIL;
                end else begin
                    wait_nx = wait_cnt + 8'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign FLASH_REQ  = (state == FREAD);
    assign RAM_REQ    = (state == RWRITE);
    assign FLASH_ADDR = FLASH_REQ ? (cur_src + offset) : 24'd0;
    assign RAM_ADDR   = RAM_REQ ? (cur_dst + offset) : 24'd0;
    assign RAM_WDATA  = wdata;
    assign BUSY       = FLASH_REQ | RAM_REQ;
    assign DONE       = (state == FIN);
    assign ERR        = (state == FAIL);

endmodule

// File: tb/tb_flash_boot_loader.sv
// Scoreboard bench for flash_boot_loader: random ACK latencies, spurious ACKs/STARTs, timeout and reset cases.
// Honours BOOT_MEGAROM_EN to decide whether the MegaROM region is expected.
module tb_flash_boot_loader;

    localparam logic [23:0] BIOS_SRC  = 24'h10_0000;
    localparam logic [23:0] BIOS_DST  = 24'h70_0000;
    localparam logic [23:0] BIOS_SIZE = 24'd4;
    localparam logic [23:0] MEGA_SRC  = 24'h20_0000;
    localparam logic [23:0] MEGA_DST  = 24'h40_0000;
    localparam logic [23:0] MEGA_SIZE = 24'd2;
    localparam logic [7:0]  TIMEOUT   = 8'd255;
`ifdef BOOT_MEGAROM_EN
    localparam int NREG = 2;
`else
    localparam int NREG = 1;
`endif
    localparam logic [23:0] REG_SRC  [2] = '{BIOS_SRC, MEGA_SRC};
    localparam logic [23:0] REG_DST  [2] = '{BIOS_DST, MEGA_DST};
    localparam logic [23:0] REG_SIZE [2] = '{BIOS_SIZE, MEGA_SIZE};

    typedef struct packed {
        logic [23:0] addr;
        logic [7:0]  data;
    } xfer_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy, done, err;
    logic        flash_req, flash_ack;
    logic [23:0] flash_addr;
    logic [7:0]  flash_rdata;
    logic        ram_req, ram_ack;
    logic [23:0] ram_addr;
    logic [7:0]  ram_wdata;

    logic [23:0] exp_flash [$];
    xfer_t       exp_ram   [$];
    bit          exp_end   [$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          withhold_idx = -1;
    logic [7:0]  seed;

    flash_boot_loader #(
        .BIOS_SRC(BIOS_SRC), .BIOS_DST(BIOS_DST), .BIOS_SIZE(BIOS_SIZE),
        .MEGA_SRC(MEGA_SRC), .MEGA_DST(MEGA_DST), .MEGA_SIZE(MEGA_SIZE),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(clk), .RESET(reset), .START(start),
        .BUSY(busy), .DONE(done), .ERR(err),
        .FLASH_REQ(flash_req), .FLASH_ADDR(flash_addr), .FLASH_ACK(flash_ack), .FLASH_RDATA(flash_rdata),
        .RAM_REQ(ram_req), .RAM_ADDR(ram_addr), .RAM_WDATA(ram_wdata), .RAM_ACK(ram_ack)
    );

    always #5 clk = ~clk;

    // Flash contents: a fixed per-run pattern of the byte address.
    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        return a[7:0] ^ a[23:16] ^ {a[3:0], a[7:4]} ^ seed;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic flushQueues();
        exp_flash.delete();
        exp_ram.delete();
        exp_end.delete();
    endtask

    // Push the whole expected copy sequence, then pulse START.
    task automatic applyStimulus(input int withhold);
        int    n = 0;
        xfer_t x;
        withhold_idx = withhold;
        for (int r = 0; r < NREG; r++) begin
            for (int o = 0; o < int'(REG_SIZE[r]); o++) begin
                if (withhold < 0 || n < withhold) begin
                    exp_flash.push_back(REG_SRC[r] + 24'(o));
                    x.addr = REG_DST[r] + 24'(o);
                    x.data = flash_byte(REG_SRC[r] + 24'(o));
                    exp_ram.push_back(x);
                end
                n++;
            end
        end
        exp_end.push_back(withhold < 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic waitEnd();
        int c = 0;
        while (exp_end.size() != 0 && c < 3000) begin
            @(posedge clk); #1;
            start = busy && ($urandom_range(0, 15) == 0);
            c++;
        end
        start = 1'b0;
        checkOutput("end_reached", 64'(exp_end.size()), 64'd0);
        flushQueues();
    endtask

    initial begin : flash_responder
        int lat;
        int cnt;
        flash_ack = 1'b0;
        flash_rdata = 8'd0;
        lat = $urandom_range(0, 2);
        cnt = 0;
        forever begin
            @(posedge clk); #1;
            flash_ack = 1'b0;
            if (!busy) cnt = 0;
            if (flash_req) begin
                if (cnt != withhold_idx) begin
                    if (lat == 0) begin
                        flash_ack = 1'b1;
                        flash_rdata = flash_byte(flash_addr);
                        cnt++;
                        lat = $urandom_range(0, 2);
                    end else begin
                        lat--;
                    end
                end
            end else if ($urandom_range(0, 3) == 0) begin
                flash_ack = 1'b1;
                flash_rdata = 8'($urandom);
            end
        end
    end

    initial begin : ram_responder
        int lat;
        ram_ack = 1'b0;
        lat = $urandom_range(0, 2);
        forever begin
            @(posedge clk); #1;
            ram_ack = 1'b0;
            if (ram_req) begin
                if (lat == 0) begin
                    ram_ack = 1'b1;
                    lat = $urandom_range(0, 2);
                end else begin
                    lat--;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                ram_ack = 1'b1;
            end
        end
    end

    initial begin : monitor
        logic  prev_done = 1'b0;
        logic  prev_err = 1'b0;
        logic  prev_freq = 1'b0;
        int    cycle = 0;
        int    rise = 0;
        int    last_ram = 0;
        xfer_t x;
        forever begin
            @(negedge clk);
            cycle++;
            if (flash_req && !prev_freq) rise = cycle;
            checkOutput("busy_vs_req", 64'(busy), 64'(flash_req | ram_req));
            if (flash_req || ram_req)
                checkOutput("req_exclusive", 64'(flash_req & ram_req), 64'd0);
            if (flash_req && flash_ack) begin
                checkOutput("flash_read_expected", 64'(exp_flash.size() != 0), 64'd1);
                if (exp_flash.size() != 0)
                    checkOutput("flash_addr", 64'(flash_addr), 64'(exp_flash.pop_front()));
            end
            if (ram_req && ram_ack) begin
                last_ram = cycle;
                checkOutput("ram_write_expected", 64'(exp_ram.size() != 0), 64'd1);
                if (exp_ram.size() != 0) begin
                    x = exp_ram.pop_front();
                    checkOutput("ram_addr", 64'(ram_addr), 64'(x.addr));
                    checkOutput("ram_wdata", 64'(ram_wdata), 64'(x.data));
                end
            end
            if ((done && !prev_done) || (err && !prev_err)) begin
                checkOutput("end_expected", 64'(exp_end.size() != 0), 64'd1);
                if (exp_end.size() != 0)
                    checkOutput("end_kind_done", 64'(done), 64'(exp_end.pop_front()));
                checkOutput("flash_queue_drained", 64'(exp_flash.size()), 64'd0);
                checkOutput("ram_queue_drained", 64'(exp_ram.size()), 64'd0);
                checkOutput("end_busy_low", 64'(busy), 64'd0);
                if (done)
                    checkOutput("done_latency", 64'(cycle - last_ram), 64'd1);
                if (err) begin
                    checkOutput("timeout_latency", 64'(cycle - rise), 64'(TIMEOUT));
                    checkOutput("timeout_flash_req", 64'(flash_req), 64'd0);
                end
            end
            prev_done = done;
            prev_err = err;
            prev_freq = flash_req;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int c;
        seed = 8'($urandom);
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_state",
                    64'({busy, done, err, flash_req, ram_req, flash_addr, ram_addr, ram_wdata}), 64'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++) begin
            applyStimulus(-1);
            waitEnd();
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
        end

        // Third flash read never acknowledged, then a clean restart.
        applyStimulus(2);
        waitEnd();
        applyStimulus(-1);
        waitEnd();

        // Reset while the second byte is being written.
        applyStimulus(-1);
        c = 0;
        while (!(ram_req && ram_addr == BIOS_DST + 24'd1) && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        checkOutput("reached_byte1_write", 64'(ram_addr), 64'(BIOS_DST + 24'd1));
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        checkOutput("reset_mid_transfer",
                    64'({busy, done, err, flash_req, ram_req, flash_addr, ram_addr, ram_wdata}), 64'd0);
        flushQueues();
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        checkOutput("idle_after_reset", 64'({busy, done, err, flash_req, ram_req}), 64'd0);

        applyStimulus(-1);
        waitEnd();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/flash_boot_loader.md
FLASH_BOOT_LOADER -- requirements
Module: flash_boot_loader

Interface
REQ-001 Parameter BIOS_SRC, default 24'h10_0000, SHALL be the flash start address of the BIOS region (Nextor and FM BIOS, contiguous).
REQ-002 Parameter BIOS_DST, default 24'h70_0000, SHALL be the RAM start address of the BIOS region.
REQ-003 Parameter BIOS_SIZE, default 24'h02_4000, SHALL be the BIOS region byte count.
REQ-004 Parameter MEGA_SRC, default 24'h20_0000, SHALL be the flash start address of the MegaROM region.
REQ-005 Parameter MEGA_DST, default 24'h40_0000, SHALL be the RAM start address of the MegaROM region.
REQ-006 Parameter MEGA_SIZE, default 24'h20_0000, SHALL be the MegaROM region byte count.
REQ-007 Parameter TIMEOUT, default 8'd255, SHALL be the maximum number of cycles to wait for an ACK.
REQ-008 Ports, clock and reset first:
- CLK  in  1  -- single clock; all logic is clocked on its rising edge.
- RESET  in  1  -- asynchronous, active-high reset.
- START  in  1  -- one-cycle copy request.
- BUSY  out  1  -- copy in progress.
- DONE  out  1  -- copy completed; sticky.
- ERR  out  1  -- ACK timeout occurred; sticky.
- FLASH_REQ  out  1  -- flash read request.
- FLASH_ADDR  out  24  -- flash byte address.
- FLASH_ACK  in  1  -- flash read data valid.
- FLASH_RDATA  in  8  -- flash read data.
- RAM_REQ  out  1  -- RAM write request.
- RAM_ADDR  out  24  -- RAM byte address.
- RAM_WDATA  out  8  -- RAM write data.
- RAM_ACK  in  1  -- RAM write accepted.

Function
REQ-009 The module SHALL implement states IDLE, FREAD, RWRITE, FIN and FAIL.
REQ-010 START sampled in IDLE, FIN or FAIL SHALL clear DONE and ERR, load region 0 (BIOS), and enter FREAD; FLASH_REQ SHALL be high the next cycle.
REQ-011 START while BUSY SHALL be ignored.
REQ-012 In FREAD, FLASH_REQ SHALL stay high with FLASH_ADDR = src + offset held stable until the cycle FLASH_ACK=1.
REQ-013 In the FLASH_ACK=1 cycle, FLASH_RDATA SHALL be latched into RAM_WDATA and the state SHALL become RWRITE; FLASH_REQ SHALL be low the following cycle.
REQ-014 In RWRITE, RAM_REQ SHALL stay high with RAM_ADDR = dst + offset and RAM_WDATA held stable until RAM_ACK=1.
REQ-015 On RAM_ACK=1, if offset = size-1, the module SHALL advance to the next region (FREAD) or, after the last region, to FIN.
REQ-016 On RAM_ACK=1 when offset < size-1, the module SHALL increment offset and return to FREAD; minimum throughput is one byte per 4 cycles.
REQ-017 A region with size 0 SHALL be skipped without any access.
REQ-018 Offset arithmetic SHALL be 24-bit; src/dst + offset SHALL wrap modulo 2^24.
REQ-019 ACK inputs SHALL be ignored when the matching REQ is low.
REQ-020 Each REQ assertion SHALL start an 8-bit wait counter.
REQ-021 If the wait counter reaches TIMEOUT without ACK, REQ SHALL drop and the state SHALL become FAIL (ERR=1, BUSY=0).
REQ-022 FIN SHALL drive DONE=1 and BUSY=0.
REQ-023 BUSY SHALL be 1 exactly in FREAD and RWRITE.
REQ-024 FLASH_REQ and RAM_REQ SHALL never be high in the same cycle.

Reset
REQ-025 RESET=1 SHALL immediately force IDLE and drive all outputs to 0 (addresses and WDATA 24'h0/8'h0), including mid-transfer; no ACK is awaited.

Configuration
REQ-026 With macro BOOT_MEGAROM_EN defined, regions SHALL be BIOS then MegaROM.
REQ-027 Without BOOT_MEGAROM_EN, only BIOS SHALL be copied; MEGA_* parameters SHALL be unused and FIN SHALL follow the last BIOS byte.

Verification
REQ-028 Test BIOS_SIZE=4, MEGA_SIZE=2, ACKs after 1 cycle, macro defined: flash reads 10_0000..10_0003 then 20_0000..20_0001; RAM writes to 70_0000.. and 40_0000.. carry the flash data; DONE=1 after the 6th RAM_ACK.
REQ-029 Same configuration with macro undefined: exactly 4 transfers occur, then DONE=1, and FLASH_ADDR never equals 20_0000.
REQ-030 FLASH_ACK withheld on byte 2: ERR=1 exactly TIMEOUT cycles after FLASH_REQ rose, with FLASH_REQ=0 and BUSY=0; a subsequent START restarts at 10_0000.
REQ-031 RESET pulsed during RWRITE of byte 1: all outputs are 0 in the same cycle; after release the module stays IDLE until START.
REQ-032 START re-pulsed while BUSY, plus spurious RAM_ACK during FREAD: the sequence, addresses and byte count are unchanged.
